// File: rtl/ps2_host_transmitter_pkg.sv
// rtl/ps2_host_transmitter_pkg.sv - shared state encoding and PS/2 frame constants
package ps2_host_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } tx_state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Bits shifted out after the start bit: D0..D7, odd parity, stop.
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        return {STOP_BIT, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronizer, stable-count filter and falling-edge flag
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic line_raw,
    output logic line_filt,
    output logic line_fall
);

    localparam int             CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle PS/2 lines sit high on the pull-up, so the filter resets to 1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync      <= 2'b11;
            cnt       <= '0;
            line_filt <= 1'b1;
            line_fall <= 1'b0;
        end else begin
            sync      <= {sync[0], line_raw};
            line_fall <= 1'b0;
            if (sync[1] == line_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                line_filt <= sync[1];
                line_fall <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_transmitter.sv
// rtl/ps2_host_transmitter.sv - host-to-device PS/2 command byte transmitter
module ps2_host_transmitter
    import ps2_host_transmitter_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       FCLK,
    input  logic       RESET_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ACK_ERR,
    output logic       TX_TIMEOUT,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);

    localparam logic [31:0] INHIBIT_LAST  = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_SEND_IDX = 4'(FRAME_BITS - 2);

    tx_state_t   state;
    logic [9:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [31:0] timer;
    logic        ack_seen;

    logic clk_filt;
    logic clk_fall;
    logic data_filt;
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk       (FCLK),
        .resetn    (RESET_N),
        .line_raw  (PS2_CLK_IN),
        .line_filt (clk_filt),
        .line_fall (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk       (FCLK),
        .resetn    (RESET_N),
        .line_raw  (PS2_DATA_IN),
        .line_filt (data_filt),
        .line_fall (data_fall_unused)
    );

    always_ff @(posedge FCLK) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            ack_seen    <= 1'b0;
            TX_BUSY     <= 1'b0;
            TX_DONE     <= 1'b0;
            TX_ACK_ERR  <= 1'b0;
            TX_TIMEOUT  <= 1'b0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
        end else begin
            TX_DONE    <= 1'b0;
            TX_ACK_ERR <= 1'b0;
            TX_TIMEOUT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (TX_START) begin
                        shreg       <= build_frame(TX_DATA);
                        TX_BUSY     <= 1'b1;
                        PS2_CLK_OE  <= 1'b1;
                        PS2_DATA_OE <= 1'b0;
                        timer       <= '0;
                        ack_seen    <= 1'b0;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        timer       <= '0;
                        PS2_DATA_OE <= ~START_BIT;
                        state       <= ST_RTS;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_RTS: begin
                    PS2_CLK_OE <= 1'b0;
                    bit_cnt    <= '0;
                    timer      <= '0;
                    state      <= ST_SEND;
                end
                ST_SEND, ST_ACK: begin
                    // Timeout wins over a falling edge landing in the same cycle.
                    if (timer == TIMEOUT_LAST) begin
                        PS2_CLK_OE  <= 1'b0;
                        PS2_DATA_OE <= 1'b0;
                        TX_TIMEOUT  <= 1'b1;
                        TX_BUSY     <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                        if (clk_fall) begin
                            if (state == ST_SEND) begin
                                PS2_DATA_OE <= ~shreg[0];
                                shreg       <= {1'b0, shreg[9:1]};
                                bit_cnt     <= bit_cnt + 4'd1;
                                if (bit_cnt == LAST_SEND_IDX)
                                    state <= ST_ACK;
                            end else begin
                                if (data_filt == 1'b0)
                                    ack_seen <= 1'b1;
                                else
                                    TX_ACK_ERR <= 1'b1;
                                state <= ST_WAIT_IDLE;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (clk_filt && data_filt) begin
                        TX_DONE <= ack_seen;
                        TX_BUSY <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb/tb_ps2_host_transmitter.sv - directed self-checking bench with a PS/2 device model
module tb_ps2_host_transmitter;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int FLEN = 8;
    localparam int H    = 40;

    logic       FCLK     = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [7:0] TX_DATA  = 8'h00;
    logic       TX_START = 1'b0;
    logic       TX_BUSY, TX_DONE, TX_ACK_ERR, TX_TIMEOUT;
    logic       PS2_CLK_OE, PS2_DATA_OE;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    assign clk_line  = dev_clk  & ~PS2_CLK_OE;
    assign data_line = dev_data & ~PS2_DATA_OE;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int tmo_cnt  = 0;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLEN)
    ) dut (
        .FCLK        (FCLK),
        .RESET_N     (RESET_N),
        .TX_DATA     (TX_DATA),
        .TX_START    (TX_START),
        .TX_BUSY     (TX_BUSY),
        .TX_DONE     (TX_DONE),
        .TX_ACK_ERR  (TX_ACK_ERR),
        .TX_TIMEOUT  (TX_TIMEOUT),
        .PS2_CLK_IN  (clk_line),
        .PS2_DATA_IN (data_line),
        .PS2_CLK_OE  (PS2_CLK_OE),
        .PS2_DATA_OE (PS2_DATA_OE)
    );

    always #5 FCLK = ~FCLK;

    always @(negedge FCLK) begin
        if (TX_DONE)    done_cnt++;
        if (TX_ACK_ERR) err_cnt++;
        if (TX_TIMEOUT) tmo_cnt++;
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge FCLK);
        TX_DATA  = d;
        TX_START = 1'b1;
        @(negedge FCLK);
        TX_START = 1'b0;
    endtask

    // Device side: waits for request-to-send, clocks out 'edges' falling edges,
    // samples the data line just before each rising edge, optionally ACKs on edge 11.
    task automatic dev_xfer(input int edges, input bit ack, input bit glitch,
                            output logic [9:0] bits, output logic start_bit, output bit ok);
        int n = 0;
        bits = '0;
        start_bit = 1'b1;
        ok = 1'b0;
        while (!(PS2_DATA_OE && !PS2_CLK_OE) && n < 4*INH + 200) begin
            @(negedge FCLK);
            n++;
        end
        if (!(PS2_DATA_OE && !PS2_CLK_OE)) return;
        ok = 1'b1;
        repeat (H) @(negedge FCLK);
        start_bit = data_line;
        for (int e = 1; e <= edges && e <= 10; e++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge FCLK);
            bits[e-1] = data_line;
            dev_clk = 1'b1;
            if (glitch) begin
                repeat (H/2) @(negedge FCLK);
                dev_clk = 1'b0;
                repeat (e % 3 + 1) @(negedge FCLK);
                dev_clk = 1'b1;
                repeat (H/2) @(negedge FCLK);
            end else begin
                repeat (H) @(negedge FCLK);
            end
        end
        if (edges >= 11) begin
            if (ack) dev_data = 1'b0;
            repeat (4) @(negedge FCLK);
            dev_clk = 1'b0;
            repeat (H) @(negedge FCLK);
            dev_clk = 1'b1;
            repeat (H) @(negedge FCLK);
            dev_data = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge FCLK);
        n_cmp++;
        if ({TX_BUSY, TX_DONE, TX_ACK_ERR, TX_TIMEOUT, PS2_CLK_OE, PS2_DATA_OE} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {TX_BUSY, TX_DONE, TX_ACK_ERR, TX_TIMEOUT, PS2_CLK_OE, PS2_DATA_OE});
        end
        RESET_N = 1'b1;
        repeat (20) @(negedge FCLK);
    endtask

    task automatic test_send_ed();
        int d0 = done_cnt, e0 = err_cnt, t0 = tmo_cnt, n = 0;
        logic [9:0] bits;
        logic sb;
        bit ok;
        start_tx(8'hED);
        n_cmp++;
        if (TX_BUSY !== 1'b1 || PS2_CLK_OE !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_latency: busy=%b clk_oe=%b want 1 1", TX_BUSY, PS2_CLK_OE);
        end
        while (PS2_CLK_OE && !PS2_DATA_OE && n < 10*INH) begin
            n++;
            @(negedge FCLK);
        end
        n_cmp++;
        if (n != INH) begin
            n_bad++;
            $display("FAIL inhibit_len: got %0d want %0d", n, INH);
        end
        dev_xfer(11, 1'b1, 1'b0, bits, sb, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ed_rts: got no request-to-send want one"); end
        n_cmp++;
        if (sb !== 1'b0) begin n_bad++; $display("FAIL ed_start_bit: got %b want 0", sb); end
        n_cmp++;
        if (bits !== 10'h3ED) begin n_bad++; $display("FAIL ed_frame: got %h want 3ed", bits); end
        repeat (60) @(negedge FCLK);
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || tmo_cnt != t0) begin
            n_bad++;
            $display("FAIL ed_status: done=%0d err=%0d tmo=%0d want 1 0 0",
                     done_cnt - d0, err_cnt - e0, tmo_cnt - t0);
        end
        n_cmp++;
        if (TX_BUSY !== 1'b0 || PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL ed_idle: busy=%b clk_oe=%b data_oe=%b want 0 0 0", TX_BUSY, PS2_CLK_OE, PS2_DATA_OE);
        end
    endtask

    task automatic test_parity_01();
        int d0 = done_cnt, e0 = err_cnt, t0 = tmo_cnt;
        logic [9:0] bits;
        logic sb;
        bit ok;
        start_tx(8'h01);
        dev_xfer(11, 1'b1, 1'b0, bits, sb, ok);
        n_cmp++;
        if (!ok || bits[8] !== 1'b0) begin
            n_bad++;
            $display("FAIL p01_parity: ok=%b got %b want 0", ok, bits[8]);
        end
        n_cmp++;
        if (bits !== 10'h201) begin n_bad++; $display("FAIL p01_frame: got %h want 201", bits); end
        repeat (60) @(negedge FCLK);
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || tmo_cnt != t0) begin
            n_bad++;
            $display("FAIL p01_status: done=%0d err=%0d tmo=%0d want 1 0 0",
                     done_cnt - d0, err_cnt - e0, tmo_cnt - t0);
        end
    endtask

    task automatic test_ack_err();
        int d0 = done_cnt, e0 = err_cnt, t0 = tmo_cnt;
        logic [9:0] bits;
        logic sb;
        bit ok;
        start_tx(8'h3C);
        dev_xfer(11, 1'b0, 1'b0, bits, sb, ok);
        n_cmp++;
        if (!ok || bits !== 10'h33C) begin
            n_bad++;
            $display("FAIL nak_frame: ok=%b got %h want 33c", ok, bits);
        end
        repeat (60) @(negedge FCLK);
        n_cmp++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || tmo_cnt != t0) begin
            n_bad++;
            $display("FAIL nak_status: err=%0d done=%0d tmo=%0d want 1 0 0",
                     err_cnt - e0, done_cnt - d0, tmo_cnt - t0);
        end
        n_cmp++;
        if (TX_BUSY !== 1'b0) begin n_bad++; $display("FAIL nak_busy: got %b want 0", TX_BUSY); end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt, e0 = err_cnt, t0 = tmo_cnt, n = 0;
        start_tx(8'h12);
        while (TX_TIMEOUT !== 1'b1 && n < INH + TMO + 500) begin
            @(negedge FCLK);
            n++;
        end
        n_cmp++;
        if (n != INH + 1 + TMO) begin
            n_bad++;
            $display("FAIL tmo_latency: got %0d want %0d", n, INH + 1 + TMO);
        end
        n_cmp++;
        if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || TX_BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_release: clk_oe=%b data_oe=%b busy=%b want 0 0 0", PS2_CLK_OE, PS2_DATA_OE, TX_BUSY);
        end
        repeat (20) @(negedge FCLK);
        n_cmp++;
        if (tmo_cnt - t0 != 1 || done_cnt != d0 || err_cnt != e0) begin
            n_bad++;
            $display("FAIL tmo_status: tmo=%0d done=%0d err=%0d want 1 0 0",
                     tmo_cnt - t0, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        logic [9:0] bits;
        logic sb;
        bit ok;
        start_tx(8'hFF);
        fork
            dev_xfer(11, 1'b1, 1'b0, bits, sb, ok);
            begin
                repeat (300) @(negedge FCLK);
                TX_DATA  = 8'h55;
                TX_START = 1'b1;
                @(negedge FCLK);
                TX_START = 1'b0;
            end
        join
        n_cmp++;
        if (!ok || bits !== 10'h3FF) begin
            n_bad++;
            $display("FAIL b2b_frame: ok=%b got %h want 3ff", ok, bits);
        end
        repeat (200) @(negedge FCLK);
        n_cmp++;
        if (done_cnt - d0 != 1 || TX_BUSY !== 1'b0 || PS2_CLK_OE !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_single: done=%0d busy=%b clk_oe=%b want 1 0 0", done_cnt - d0, TX_BUSY, PS2_CLK_OE);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt, e0 = err_cnt, t0 = tmo_cnt;
        logic [9:0] bits;
        logic sb;
        bit ok;
        start_tx(8'h5A);
        dev_xfer(4, 1'b1, 1'b0, bits, sb, ok);
        @(negedge FCLK);
        RESET_N = 1'b0;
        @(posedge FCLK);
        #1;
        n_cmp++;
        if (PS2_CLK_OE !== 1'b0 || PS2_DATA_OE !== 1'b0 || TX_BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_release: clk_oe=%b data_oe=%b busy=%b want 0 0 0", PS2_CLK_OE, PS2_DATA_OE, TX_BUSY);
        end
        repeat (5) @(negedge FCLK);
        RESET_N = 1'b1;
        repeat (30) @(negedge FCLK);
        n_cmp++;
        if (done_cnt != d0 || err_cnt != e0 || tmo_cnt != t0) begin
            n_bad++;
            $display("FAIL rst_mid_pulse: done=%0d err=%0d tmo=%0d want 0 0 0",
                     done_cnt - d0, err_cnt - e0, tmo_cnt - t0);
        end
        start_tx(8'hC3);
        dev_xfer(11, 1'b1, 1'b0, bits, sb, ok);
        repeat (60) @(negedge FCLK);
        n_cmp++;
        if (!ok || bits !== 10'h3C3 || done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL rst_mid_recover: ok=%b frame=%h done=%0d want 1 3c3 1", ok, bits, done_cnt - d0);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt, e0 = err_cnt;
        logic [9:0] bits;
        logic sb;
        bit ok;
        start_tx(8'hA5);
        dev_xfer(11, 1'b1, 1'b1, bits, sb, ok);
        n_cmp++;
        if (!ok || bits !== 10'h3A5) begin
            n_bad++;
            $display("FAIL glitch_frame: ok=%b got %h want 3a5", ok, bits);
        end
        repeat (60) @(negedge FCLK);
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            n_bad++;
            $display("FAIL glitch_status: done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity_01();
        test_ack_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same PS/2 CLK/DATA lines the scan-code receiver listens on. Runs entirely in the FCLK domain. Drives both lines open-drain: an output-enable pulls the line low, and releasing it lets the pull-up take it high. It signals busy/done/error so a command sequencer can hold off the receiver while a transmit is in progress.

Parameters:
INHIBIT_CYCLES, 5000, FCLK cycles PS2 CLK is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum FCLK cycles from clock release to ACK sample (15 ms at 50 MHz).
FILTER_LEN, 8, consecutive equal samples required before a filtered line changes state.

Ports:
FCLK input 1 system clock; all logic on its rising edge.
RESET_N input 1 synchronous active-low reset.
TX_DATA input 8 command byte; captured on an accepted TX_START.
TX_START input 1 one-cycle request; honoured only in IDLE.
TX_BUSY output 1 high from the accept cycle until return to IDLE.
TX_DONE output 1 one-cycle pulse; transfer ended with device ACK.
TX_ACK_ERR output 1 one-cycle pulse; device did not ACK (data high at edge 11).
TX_TIMEOUT output 1 one-cycle pulse; TIMEOUT_CYCLES expired.
PS2_CLK_IN input 1 raw PS/2 clock line (asynchronous).
PS2_DATA_IN input 1 raw PS/2 data line (asynchronous).
PS2_CLK_OE output 1 1 = pull PS/2 clock low.
PS2_DATA_OE output 1 1 = pull PS/2 data low.

Behaviour:
- Reset: all outputs 0, both lines released, state IDLE, counters 0. Reset in the middle of a transfer releases both lines on the next FCLK edge.
- Each input passes a 2-flop synchronizer and then a FILTER_LEN stable-count filter. A falling edge is filtered clock 1 -> 0, flagged for one cycle.
- Data is captured at accept. Shift frame = {stop = 1, parity = ~^TX_DATA (odd), D7..D0}, sent LSB first.
- IDLE: when TX_START = 1, capture TX_DATA, set TX_BUSY, go to INHIBIT.
- INHIBIT: CLK_OE = 1, DATA_OE = 0 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: DATA_OE = 1 (start bit 0), then CLK_OE = 0 one cycle later. Clear the bit counter and start the timeout counter. Go to SEND.
- SEND: on each filtered falling edge n = 1..10, drive frame bit n-1. DATA_OE = ~bit, so edge 9 drives parity and edge 10 releases data (stop). After edge 10, go to ACK.
- ACK: on falling edge 11, sample filtered data. Low means ACK, go to WAIT_IDLE. High means pulse TX_ACK_ERR and go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered CLK and DATA are both 1. Pulse TX_DONE if ACK was seen. Return to IDLE; TX_BUSY drops in the same cycle.
- Timeout: if the counter reaches TIMEOUT_CYCLES in SEND or ACK, release both lines, pulse TX_TIMEOUT, and go to IDLE. Timeout takes priority over a falling edge arriving in the same cycle.
- TX_START while TX_BUSY is ignored; no queueing.
- TX_DONE, TX_ACK_ERR and TX_TIMEOUT are mutually exclusive. At most one pulses per transfer.
- Latency from accept to the first line change: 1 cycle (CLK_OE asserted).

Decomposition:
- Shared package: state encoding (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE) and the PS/2 frame constants (FRAME_BITS = 11, START_BIT = 0, STOP_BIT = 1).
- One sub-module: ps2_line_filter (synchronizer, stable-count filter, falling-edge flag). Instantiated twice, once for CLK and once for DATA.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz -> CLK_OE low for 5000 cycles. Data bits on the line are 1,0,1,1,0,1,1,1, then parity 1, then stop released. Model ACKs -> one TX_DONE pulse and TX_BUSY falls.
- Send 0x01 -> parity bit 0 observed at falling edge 9. Model ACKs -> TX_DONE, with no ACK_ERR and no TIMEOUT.
- Model leaves data high at edge 11 -> TX_ACK_ERR pulses once and TX_DONE stays 0.
- Model never generates a clock -> after TIMEOUT_CYCLES, TX_TIMEOUT pulses, both OE outputs are 0 and the state is IDLE.
- TX_START with 0x55 while busy sending 0xFF -> only 0xFF appears on the line, followed by a single TX_DONE.
- RESET_N asserted low after edge 4 of a transfer -> on the next FCLK edge both OE outputs are 0, TX_BUSY is 0 and no status pulse occurs. A new transfer after reset completes normally.
- Glitches of 1-3 cycles on PS2_CLK_IN -> no extra bit shifts, and the transfer stays correct.
